// File: rtl/mem_access_if.sv
// -----------------------------------------------------------------------------
// mem_access_if
// Data-port bundle between the memory-access stage and the data memory.
// The request is held stable by the master until the slave returns DATA_ACK.
//
//   DATA_REQ     master -> slave  access request
//   DATA_WREN    master -> slave  write qualifier for DATA_REQ
//   DATA_ADDR    master -> slave  byte address
//   DATA_STRB    master -> slave  write byte strobes (one per lane)
//   DATA_WDATA   master -> slave  pre-aligned write data
//   DATA_ACK     slave  -> master completes the outstanding request
//   DATA_RDDATA  slave  -> master read data, valid in the DATA_ACK cycle
// -----------------------------------------------------------------------------
interface mem_access_if #(
    parameter int XLEN = 32
) ();
    logic                DATA_REQ;
    logic                DATA_WREN;
    logic [XLEN-1:0]     DATA_ADDR;
    logic [XLEN/8-1:0]   DATA_STRB;
    logic [XLEN-1:0]     DATA_WDATA;
    logic                DATA_ACK;
    logic [XLEN-1:0]     DATA_RDDATA;

    modport master (
        output DATA_REQ, DATA_WREN, DATA_ADDR, DATA_STRB, DATA_WDATA,
        input  DATA_ACK, DATA_RDDATA
    );

    modport slave (
        input  DATA_REQ, DATA_WREN, DATA_ADDR, DATA_STRB, DATA_WDATA,
        output DATA_ACK, DATA_RDDATA
    );
endinterface

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
// Memory-access stage of the RV pipeline (between ALU and write-back).
// Latches the ALU-stage result, runs loads/stores over a variable-latency
// request/acknowledge data port and holds upstream (BUSY) while an access is
// outstanding. Load data is lane-aligned by the address offset, then
// size/sign extracted.
//
// Parameters: XLEN (32 or 64); LANES and OFS_W are derived.
// Ports:
//   CLK, RSTN            clock, synchronous active-low reset
//   STALL, FLUSH         downstream hold, squash stage contents
//   BUSY                 upstream hold, high while a request is outstanding
//   DO_JMP, NEW_PC       registered jump request (gated by stage valid)
//   A_*                  ALU-stage inputs (PC, inst, result, load/store ctrl)
//   dbus                 data-memory port (mem_access_if.master)
//   M_*                  results toward write-back, incl. M_EXC/M_EXC_CAUSE
//
// Optional feature: define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned
// half/word/dword accesses (cause 4 load, 6 store) instead of issuing them.
// -----------------------------------------------------------------------------
module mem_access #(
    parameter  int XLEN  = 32,
    localparam int LANES = XLEN / 8,
    localparam int OFS_W = $clog2(LANES)
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              STALL,
    input  logic              FLUSH,
    output logic              BUSY,
    output logic              DO_JMP,
    output logic [XLEN-1:0]   NEW_PC,
    input  logic [XLEN-1:0]   A_PC,
    input  logic [31:0]       A_INST,
    input  logic [XLEN-1:0]   A_NEW_PC,
    input  logic              A_VALID,
    input  logic              A_DO_JMP,
    input  logic [4:0]        A_REG_D,
    input  logic [XLEN-1:0]   A_REG_D_V,
    input  logic              A_LOAD_RDEN,
    input  logic              A_LOAD_SIGNED,
    input  logic [1:0]        A_LOAD_SIZE,
    input  logic [XLEN-1:0]   A_MEM_ADDR,
    input  logic              A_STORE_WREN,
    input  logic [LANES-1:0]  A_STORE_STRB,
    input  logic [XLEN-1:0]   A_STORE_DATA,
    mem_access_if.master      dbus,
    output logic [XLEN-1:0]   M_PC,
    output logic [31:0]       M_INST,
    output logic              M_VALID,
    output logic [4:0]        M_REG_D,
    output logic [XLEN-1:0]   M_REG_D_V,
    output logic              M_EXC,
    output logic [3:0]        M_EXC_CAUSE
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t state, state_nxt;

    logic             valid_p1, do_jmp_p1, load_p1, sign_p1, store_p1;
    logic             kill_p1, ld_done_p1;
    logic [XLEN-1:0]  pc_p1, new_pc_p1, reg_d_v_p1, addr_p1, wdata_p1, ld_res_p1;
    logic [31:0]      inst_p1;
    logic [4:0]       reg_d_p1;
    logic [1:0]       size_p1;
    logic [LANES-1:0] strb_p1;
    logic             trap_a;

    // Keep the low 'width' bits of an already lane-shifted word and fill the
    // rest with the sign bit (signed) or zero. Dword only exists for XLEN=64.
    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] d,
                                                input logic [1:0]      sz,
                                                input logic            sgn);
        int              width;
        logic            ext;
        logic [XLEN-1:0] r;
        case (sz)
            2'b00:   width = 8;
            2'b01:   width = 16;
            2'b10:   width = 32;
            default: width = (XLEN == 64) ? 64 : 32;
        endcase
        ext = sgn && d[width-1];
        for (int i = 0; i < XLEN; i++)
            r[i] = (i < width) ? d[i] : ext;
        return r;
    endfunction

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic       exc_p1;
    logic [3:0] cause_p1;

    function automatic logic misaligned(input logic [2:0] a, input logic [1:0] sz);
        case (sz)
            2'b01:   return a[0];
            2'b10:   return a[1:0] != 2'b00;
            2'b11:   return (XLEN == 64) ? (a != 3'b000) : (a[1:0] != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    assign trap_a = A_VALID && (A_LOAD_RDEN || A_STORE_WREN) &&
                    misaligned(A_MEM_ADDR[2:0], A_LOAD_SIZE);
`else
    assign trap_a = 1'b0;
`endif

    // ---- state register ----
    always_ff @(posedge CLK) begin
        if (!RSTN) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!STALL && !FLUSH && A_VALID && (A_LOAD_RDEN || A_STORE_WREN) && !trap_a)
                      state_nxt = REQ;
            REQ:  if (dbus.DATA_ACK)
                      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- ALU stage -> p1 stage registers ----
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            valid_p1   <= 1'b0;  do_jmp_p1 <= 1'b0;  load_p1  <= 1'b0;
            sign_p1    <= 1'b0;  store_p1  <= 1'b0;  kill_p1  <= 1'b0;
            ld_done_p1 <= 1'b0;  pc_p1     <= '0;    new_pc_p1 <= '0;
            reg_d_v_p1 <= '0;    addr_p1   <= '0;    wdata_p1 <= '0;
            ld_res_p1  <= '0;    inst_p1   <= '0;    reg_d_p1 <= '0;
            size_p1    <= '0;    strb_p1   <= '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            exc_p1     <= 1'b0;  cause_p1  <= '0;
`endif
        end else if (state == REQ) begin
            // A flush cannot abort the handshake; remember it and drop the
            // stage valid bit once the memory has acknowledged.
            if (FLUSH) kill_p1 <= 1'b1;
            if (dbus.DATA_ACK) begin
                if (load_p1) begin
                    ld_res_p1  <= extract(dbus.DATA_RDDATA >> {addr_p1[OFS_W-1:0], 3'b000},
                                          size_p1, sign_p1);
                    ld_done_p1 <= 1'b1;
                end
                if (kill_p1 || FLUSH) valid_p1 <= 1'b0;
                kill_p1 <= 1'b0;
            end
        end else if (!STALL) begin
            if (FLUSH) begin
                valid_p1   <= 1'b0;
                ld_done_p1 <= 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                exc_p1     <= 1'b0;
                cause_p1   <= '0;
`endif
            end else begin
                valid_p1   <= A_VALID;
                do_jmp_p1  <= A_DO_JMP;
                pc_p1      <= A_PC;
                inst_p1    <= A_INST;
                new_pc_p1  <= A_NEW_PC;
                reg_d_p1   <= A_REG_D;
                reg_d_v_p1 <= A_REG_D_V;
                load_p1    <= A_LOAD_RDEN;
                sign_p1    <= A_LOAD_SIGNED;
                size_p1    <= A_LOAD_SIZE;
                addr_p1    <= A_MEM_ADDR;
                store_p1   <= A_STORE_WREN;
                strb_p1    <= A_STORE_STRB;
                wdata_p1   <= A_STORE_DATA;
                kill_p1    <= 1'b0;
                ld_done_p1 <= 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                exc_p1     <= trap_a;
                cause_p1   <= trap_a ? (A_STORE_WREN ? 4'd6 : 4'd4) : 4'd0;
`endif
            end
        end
    end

    // ---- p1 stage -> outputs ----
    assign BUSY            = (state == REQ);
    assign dbus.DATA_REQ   = (state == REQ);
    assign dbus.DATA_WREN  = (state == REQ) && store_p1;
    assign dbus.DATA_ADDR  = addr_p1;
    assign dbus.DATA_STRB  = strb_p1;
    assign dbus.DATA_WDATA = wdata_p1;

    assign DO_JMP    = do_jmp_p1 && valid_p1;
    assign NEW_PC    = new_pc_p1;
    assign M_PC      = pc_p1;
    assign M_INST    = inst_p1;
    assign M_VALID   = valid_p1 && (state == IDLE);
    assign M_REG_D_V = ld_done_p1 ? ld_res_p1 : reg_d_v_p1;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign M_REG_D     = exc_p1 ? 5'd0 : reg_d_p1;
    assign M_EXC       = exc_p1;
    assign M_EXC_CAUSE = cause_p1;
`else
    assign M_REG_D     = reg_d_p1;
    assign M_EXC       = 1'b0;
    assign M_EXC_CAUSE = 4'd0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access
// Self-checking bench for mem_access: one XLEN=32 instance exercised with
// directed and randomized operations, plus an XLEN=64 instance for wide loads.
// Expected load data comes from a byte-level reference model.
// -----------------------------------------------------------------------------
module tb_mem_access;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // ---------------- XLEN=32 instance ----------------
    logic        stall, flush, busy, do_jmp;
    logic [31:0] new_pc, a_pc, a_inst, a_new_pc, a_reg_d_v, a_mem_addr, a_store_data;
    logic        a_valid, a_do_jmp, a_load_rden, a_load_signed, a_store_wren;
    logic [4:0]  a_reg_d, m_reg_d;
    logic [1:0]  a_load_size;
    logic [3:0]  a_store_strb, m_exc_cause;
    logic [31:0] m_pc, m_inst, m_reg_d_v;
    logic        m_valid, m_exc;

    mem_access_if #(.XLEN(32)) bus32 ();

    mem_access #(.XLEN(32)) u_dut32 (
        .CLK(clk), .RSTN(rstn), .STALL(stall), .FLUSH(flush), .BUSY(busy),
        .DO_JMP(do_jmp), .NEW_PC(new_pc),
        .A_PC(a_pc), .A_INST(a_inst), .A_NEW_PC(a_new_pc), .A_VALID(a_valid),
        .A_DO_JMP(a_do_jmp), .A_REG_D(a_reg_d), .A_REG_D_V(a_reg_d_v),
        .A_LOAD_RDEN(a_load_rden), .A_LOAD_SIGNED(a_load_signed), .A_LOAD_SIZE(a_load_size),
        .A_MEM_ADDR(a_mem_addr), .A_STORE_WREN(a_store_wren), .A_STORE_STRB(a_store_strb),
        .A_STORE_DATA(a_store_data), .dbus(bus32),
        .M_PC(m_pc), .M_INST(m_inst), .M_VALID(m_valid), .M_REG_D(m_reg_d),
        .M_REG_D_V(m_reg_d_v), .M_EXC(m_exc), .M_EXC_CAUSE(m_exc_cause)
    );

    // ---------------- XLEN=64 instance ----------------
    logic        x_valid, x_sg, x_busy, x_do_jmp, x_m_valid, x_m_exc;
    logic [1:0]  x_sz;
    logic [63:0] x_addr, x_rdv, x_new_pc, x_m_pc, x_m_reg_d_v;
    logic [31:0] x_m_inst;
    logic [4:0]  x_m_reg_d;
    logic [3:0]  x_m_exc_cause;

    mem_access_if #(.XLEN(64)) bus64 ();

    mem_access #(.XLEN(64)) u_dut64 (
        .CLK(clk), .RSTN(rstn), .STALL(1'b0), .FLUSH(1'b0), .BUSY(x_busy),
        .DO_JMP(x_do_jmp), .NEW_PC(x_new_pc),
        .A_PC(64'h0), .A_INST(32'h0), .A_NEW_PC(64'h0), .A_VALID(x_valid),
        .A_DO_JMP(1'b0), .A_REG_D(5'd3), .A_REG_D_V(x_rdv),
        .A_LOAD_RDEN(1'b1), .A_LOAD_SIGNED(x_sg), .A_LOAD_SIZE(x_sz),
        .A_MEM_ADDR(x_addr), .A_STORE_WREN(1'b0), .A_STORE_STRB(8'h00),
        .A_STORE_DATA(64'h0), .dbus(bus64),
        .M_PC(x_m_pc), .M_INST(x_m_inst), .M_VALID(x_m_valid), .M_REG_D(x_m_reg_d),
        .M_REG_D_V(x_m_reg_d_v), .M_EXC(x_m_exc), .M_EXC_CAUSE(x_m_exc_cause)
    );

    // ---------------- reference model ----------------
    function automatic int nbytes(input int sz, input int xlen);
        case (sz)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return (xlen == 64) ? 8 : 4;
        endcase
    endfunction

    function automatic bit misal(input longint unsigned addr, input int sz, input int xlen);
        int n = nbytes(sz, xlen);
        return (n > 1) && ((addr % n) != 0);
    endfunction

    // Gather n bytes starting at the lane offset; lanes past the top read as 0.
    function automatic longint unsigned ref_load(input longint unsigned rd, input longint unsigned addr,
                                                 input int sz, input bit sgn, input int xlen);
        int lanes = xlen / 8;
        int n     = nbytes(sz, xlen);
        int o     = int'(addr % lanes);
        longint unsigned v = 0;
        for (int i = 0; i < n; i++)
            if (o + i < lanes)
                v |= ((rd >> (8 * (o + i))) & 64'hFF) << (8 * i);
        if (sgn && (8 * n < xlen) && (((v >> (8 * n - 1)) & 1) == 1))
            v |= ~((64'd1 << (8 * n)) - 1);
        if (xlen == 32) v &= 64'hFFFF_FFFF;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op, run its memory handshake (if any) and check M_* after it.
    task automatic run_op(input bit v, input bit ld, input bit st, input logic [31:0] addr,
                          input logic [1:0] sz, input bit sg, input logic [3:0] strb,
                          input logic [31:0] wd, input logic [31:0] rd, input int waits,
                          input bit fl, input bit jmp);
        logic [31:0] pc, rdv;
        logic [4:0]  rdst;
        bit          mem, trap, mv;
        pc   = $urandom;
        rdv  = $urandom;
        rdst = 5'($urandom_range(1, 31));
        a_pc = pc; a_inst = $urandom; a_new_pc = $urandom; a_valid = v; a_do_jmp = jmp;
        a_reg_d = rdst; a_reg_d_v = rdv; a_load_rden = ld; a_load_signed = sg;
        a_load_size = sz; a_mem_addr = addr; a_store_wren = st; a_store_strb = strb;
        a_store_data = wd; stall = 1'b0; flush = 1'b0;
        mem  = v && (ld || st);
        trap = TRAP && mem && misal(addr, sz, 32);
        step();
        // upstream offers a different op while the stage may be busy
        a_pc = ~pc; a_valid = 1'b1; a_load_rden = 1'b0; a_store_wren = 1'b0;
        a_reg_d_v = ~rdv; stall = 1'($urandom_range(0, 1));
        if (mem && !trap) begin
            chk("req_busy", busy, 1);
            chk("req_data_req", bus32.DATA_REQ, 1);
            chk("req_addr", bus32.DATA_ADDR, addr);
            chk("req_wren", bus32.DATA_WREN, st);
            chk("req_m_valid", m_valid, 0);
            if (st) begin
                chk("req_strb", bus32.DATA_STRB, strb);
                chk("req_wdata", bus32.DATA_WDATA, wd);
            end
            for (int w = 0; w < waits; w++) begin
                flush = fl && (w == 0);
                step();
                chk("wait_busy", busy, 1);
                chk("wait_data_req", bus32.DATA_REQ, 1);
                chk("wait_addr", bus32.DATA_ADDR, addr);
            end
            flush = fl && (waits == 0);
            bus32.DATA_ACK = 1'b1;
            bus32.DATA_RDDATA = rd;
            step();
            bus32.DATA_ACK = 1'b0;
            bus32.DATA_RDDATA = $urandom;
            flush = 1'b0;
        end
        mv = v && !(fl && mem && !trap);
        chk("post_busy", busy, 0);
        chk("post_data_req", bus32.DATA_REQ, 0);
        chk("post_m_valid", m_valid, mv);
        chk("post_do_jmp", do_jmp, mv && jmp);
        chk("post_m_pc", m_pc, pc);
        chk("post_m_reg_d", m_reg_d, trap ? 5'd0 : rdst);
        chk("post_m_reg_d_v", m_reg_d_v,
            (mem && ld && !trap) ? ref_load({32'b0, rd}, {32'b0, addr}, sz, sg, 32) : {32'b0, rdv});
        chk("post_m_exc", m_exc, trap);
        chk("post_m_exc_cause", m_exc_cause, trap ? (st ? 4'd6 : 4'd4) : 4'd0);
        stall = 1'b0;
    endtask

    task automatic run64(input logic [63:0] addr, input logic [1:0] sz, input bit sg,
                         input logic [63:0] rd, input int waits);
        x_valid = 1'b1; x_addr = addr; x_sz = sz; x_sg = sg; x_rdv = {$urandom, $urandom};
        step();
        x_valid = 1'b0;
        chk("x64_req", bus64.DATA_REQ, 1);
        for (int w = 0; w < waits; w++) step();
        bus64.DATA_ACK = 1'b1;
        bus64.DATA_RDDATA = rd;
        step();
        bus64.DATA_ACK = 1'b0;
        chk("x64_busy", x_busy, 0);
        chk("x64_m_valid", x_m_valid, 1);
        chk("x64_load", x_m_reg_d_v, ref_load(rd, addr, sz, sg, 64));
    endtask

    initial begin
        rstn = 1'b0; stall = 1'b0; flush = 1'b0;
        a_pc = '0; a_inst = '0; a_new_pc = '0; a_valid = 1'b0; a_do_jmp = 1'b0;
        a_reg_d = '0; a_reg_d_v = '0; a_load_rden = 1'b0; a_load_signed = 1'b0;
        a_load_size = '0; a_mem_addr = '0; a_store_wren = 1'b0; a_store_strb = '0;
        a_store_data = '0;
        bus32.DATA_ACK = 1'b0; bus32.DATA_RDDATA = '0;
        bus64.DATA_ACK = 1'b0; bus64.DATA_RDDATA = '0;
        x_valid = 1'b0; x_addr = '0; x_sz = '0; x_sg = 1'b0; x_rdv = '0;
        step(); step();

        // reset state
        chk("rst_busy", busy, 0);
        chk("rst_data_req", bus32.DATA_REQ, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_do_jmp", do_jmp, 0);
        chk("rst_m_exc", m_exc, 0);
        chk("rst_m_reg_d_v", m_reg_d_v, 0);
        chk("rst_addr", bus32.DATA_ADDR, 0);
        chk("rst_x64_busy", x_busy, 0);
        rstn = 1'b1;
        step();

        // signed byte load at lane 3, three wait cycles
        run_op(1, 1, 0, 32'h103, 2'b00, 1, 4'h0, 32'h0, 32'h80FF_1234, 3, 0, 0);
        chk("lb_value", m_reg_d_v, 32'hFFFF_FF80);
        step();
        chk("lb_one_cycle", m_reg_d_v, a_reg_d_v);

        // store squashed by a flush during the request
        run_op(1, 0, 1, 32'h40, 2'b10, 0, 4'b1100, 32'hAABB_0000, 32'h0, 2, 1, 1);

        // half load at an odd address
        run_op(1, 1, 0, 32'h101, 2'b01, 0, 4'h0, 32'h0, 32'h00AB_CD00, 1, 0, 0);
        chk("lh_odd_value", m_reg_d_v, TRAP ? m_reg_d_v : 32'h0000_ABCD);

        // downstream stall freezes M_*
        a_valid = 1'b1; a_load_rden = 1'b0; a_store_wren = 1'b0;
        a_pc = 32'h1000; a_reg_d_v = 32'h1111;
        step();
        chk("stall_cap_pc", m_pc, 32'h1000);
        stall = 1'b1; a_pc = 32'h2000; a_reg_d_v = 32'h2222;
        step();
        chk("stall_hold_pc", m_pc, 32'h1000);
        step();
        chk("stall_hold_v", m_reg_d_v, 32'h1111);
        stall = 1'b0;
        step();
        chk("stall_rel_pc", m_pc, 32'h2000);
        chk("stall_rel_v", m_reg_d_v, 32'h2222);
        flush = 1'b1;
        step();
        chk("flush_idle_valid", m_valid, 0);
        flush = 1'b0;

        // reset while a request is outstanding
        a_valid = 1'b1; a_load_rden = 1'b1; a_load_size = 2'b10; a_mem_addr = 32'h80;
        step();
        chk("rstreq_busy", busy, 1);
        rstn = 1'b0; a_valid = 1'b0;
        step();
        chk("rstreq_data_req", bus32.DATA_REQ, 0);
        chk("rstreq_busy_low", busy, 0);
        chk("rstreq_m_valid", m_valid, 0);
        rstn = 1'b1;
        step();

        // randomized ops
        for (int k = 0; k < 80; k++) begin
            int          kind;
            bit          v;
            logic [31:0] addr;
            kind = $urandom_range(0, 2);
            v    = ($urandom_range(0, 7) != 0);
            addr = $urandom;
            run_op(v, kind == 1, kind == 2, addr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   4'($urandom), $urandom, $urandom, $urandom_range(0, 3),
                   (kind != 0) && ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
        end

        // XLEN=64 loads
        run64(64'h204, 2'b10, 0, 64'h89AB_CDEF_0000_0001, 0);
        chk("x64_lwu_value", x_m_reg_d_v, 64'h0000_0000_89AB_CDEF);
        for (int k = 0; k < 12; k++) begin
            int          sz;
            logic [63:0] a;
            sz = $urandom_range(0, 3);
            a  = {32'h0, $urandom} & ~(64'(nbytes(sz, 64)) - 64'd1);
            run64(a, 2'(sz), 1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Parametrised memory-access stage of the RV pipeline, sitting between the ALU stage and write-back. It latches ALU-stage results and runs loads and stores over a variable-latency request/acknowledge data port, stalling upstream while an access is outstanding. Load data is lane-aligned from the address offset and then size/sign-extracted. It supports XLEN of 32 or 64 and optional misalignment trapping.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- LANES, XLEN/8, byte lanes; derived, not overridable.
- OFS_W, log2(LANES), address offset bits used for lane selection.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RSTN  in  1  reset, synchronous and active-low.
- STALL  in  1  downstream hold.
- FLUSH  in  1  squash the stage contents.
- BUSY  out  1  upstream hold request; high whenever state is REQ.
- DO_JMP / NEW_PC  out  1 / XLEN  registered jump request; DO_JMP is gated by the stage valid bit.
- A_PC, A_INST, A_NEW_PC  in  XLEN/32/XLEN  ALU-stage PC, instruction and jump target.
- A_VALID, A_DO_JMP  in  1  ALU-stage valid and jump flag.
- A_REG_D, A_REG_D_V  in  5 / XLEN  destination register and ALU result.
- A_LOAD_RDEN, A_LOAD_SIGNED  in  1  load enable and sign-extension select.
- A_LOAD_SIZE  in  2  00 byte, 01 half, 10 word, 11 dword (XLEN=64 only; decoded as word when XLEN=32).
- A_MEM_ADDR  in  XLEN  byte address for loads and stores.
- A_STORE_WREN, A_STORE_STRB, A_STORE_DATA  in  1 / LANES / XLEN  pre-aligned store.
- DATA_REQ  out  1  memory request.
- DATA_WREN  out  1  write qualifier for DATA_REQ.
- DATA_ADDR  out  XLEN  access address.
- DATA_STRB  out  LANES  write byte strobes.
- DATA_WDATA  out  XLEN  write data.
- DATA_ACK  in  1  completes the current request.
- DATA_RDDATA  in  XLEN  read data; valid in the DATA_ACK cycle.
- M_PC, M_INST, M_VALID, M_REG_D, M_REG_D_V  out  to write-back.
- M_EXC, M_EXC_CAUSE  out  1 / 4  exception flag and cause (see Configuration).

## Operation
- State machine states: IDLE, REQ.
- Edge priority: reset, then REQ handling, then STALL (hold), then FLUSH (clear), then capture.
- Capture occurs when state is IDLE and STALL=0. All A_* fields are registered.
- If the captured op has A_VALID and either A_LOAD_RDEN or A_STORE_WREN, the next state is REQ.
- REQ:
  - DATA_REQ=1.
  - DATA_ADDR, DATA_STRB, DATA_WDATA and DATA_WREN come from registers and are stable until ACK.
  - M_VALID=0.
  - STALL and FLUSH do not abort the handshake.
  - FLUSH seen in REQ sets a kill bit. The transaction completes, then the stage valid bit is cleared.
- On DATA_ACK in REQ:
  - For a load, register the extract(DATA_RDDATA >> 8*addr[OFS_W-1:0], size, signed) result into the result register.
  - Return to IDLE.
- In IDLE:
  - M_REG_D_V shows the load result for a completed load and the registered A_REG_D_V otherwise.
  - Other M_* fields mirror the stage registers.
- Extraction:
  - Byte and half follow the sign rule from A_LOAD_SIGNED; word also does when XLEN=64.
  - Bytes shifted in past lane LANES-1 are zero.
- A non-memory op, or one with A_VALID=0, never enters REQ.

## Timing
- Reset: every register is 0; state is IDLE.
  - All outputs are 0, including BUSY, DATA_REQ, DO_JMP and M_EXC.
- ALU op: captured at edge N and visible on M_* after edge N.
- Memory op: captured at edge N; REQ starts in cycle N+1.
  - An ACK in the first REQ cycle gives a result after edge N+2.
  - Each extra wait cycle adds 1 cycle.
- BUSY is combinational from state, so upstream sees the hold in the first REQ cycle.
  - No new capture is possible at the ACK edge; the earliest next capture is the edge after it.
- A DATA_ACK seen outside REQ is ignored.
- Reset asserted mid-REQ drops DATA_REQ on the next edge. Memory must tolerate an abandoned request.

## Configuration
- MEM_ACCESS_MISALIGN_TRAP_EN defined:
  - Misalignment rules: half with addr[0]≠0; word with addr[1:0]≠0; dword with addr[2:0]≠0.
  - A misaligned op skips REQ and presents M_VALID=1 and M_EXC=1.
  - M_EXC_CAUSE is 4 for a load and 6 for a store.
  - M_REG_D is forced to 0.
- Not defined:
  - M_EXC and M_EXC_CAUSE are tied to 0.
  - Misaligned ops are issued as-is and use the zero-fill extraction rule.

## Test plan
- XLEN=32, load byte signed at addr 0x103, RDDATA 0x80FF_1234, ACK after 3 wait cycles -> BUSY high for 4 cycles; M_REG_D_V=0xFFFF_FF80 visible for 1 cycle after ACK.
- XLEN=64, load word unsigned at addr 0x204, RDDATA 0x89AB_CDEF_0000_0001 -> M_REG_D_V=0x0000_0000_89AB_CDEF.
- Store at addr 0x40, STRB 0b1100, data 0xAABB_0000, FLUSH asserted during REQ -> DATA_REQ held until ACK; afterwards M_VALID=0 and DO_JMP=0.
- ALU op with STALL high for 2 cycles -> M_* frozen; A_* changes are not captured until STALL drops.
- With the macro, load half at 0x101 -> no DATA_REQ; M_EXC=1, M_EXC_CAUSE=4, M_REG_D=0. Without the macro -> DATA_REQ issued, result {16'b0, RDDATA[23:8]} when unsigned.
- RSTN low during REQ -> DATA_REQ=0, BUSY=0 and M_VALID=0 on the next edge.
